// File: rtl/sprite_pkg.sv
// sprite_pkg: shared geometry, width constants and plotter state encoding
package sprite_pkg;
  localparam int CELL_W   = 5;
  localparam int CELL_H   = 5;
  localparam int ADDR_W   = 5;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int X_MAX    = 160;
  localparam int Y_MAX    = 120;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;
endpackage

// File: rtl/sprite_plotter_if.sv
// sprite_plotter_if: controller, ROM and VGA-port signals of the sprite plotter
// slave: plotter side (drives rom_addr, vga_*, busy, done)
// master: environment side (drives start, base_x, base_y, rom_data)
interface sprite_plotter_if;
  import sprite_pkg::*;
  logic                start;
  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                busy;
  logic                done;
  modport slave (input start, base_x, base_y, rom_data,
                 output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done);
  modport master (output start, base_x, base_y, rom_data,
                  input rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done);
endinterface

// File: rtl/cell_walker.sv
// cell_walker: row-major cx/cy walk over a character cell with a linear address counter
// clear: zero all counters; step: advance one cell; last: address is the final cell
module cell_walker #(
  parameter int CELL_W = 5,
  parameter int CELL_H = 5,
  parameter int ADDR_W = 5,
  parameter int CX_W   = $clog2(CELL_W),
  parameter int CY_W   = $clog2(CELL_H)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              step,
  output logic [CX_W-1:0]   cx,
  output logic [CY_W-1:0]   cy,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [CX_W-1:0]   cx_q, cx_d;
  logic [CY_W-1:0]   cy_q, cy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap;
  always_comb begin
    wrap   = cx_q == CX_W'(CELL_W - 1);
    cx_d   = clear ? '0 : step ? (wrap ? '0 : cx_q + CX_W'(1)) : cx_q;
    cy_d   = clear ? '0 : (step && wrap) ? cy_q + CY_W'(1) : cy_q;
    addr_d = clear ? '0 : step ? addr_q + ADDR_W'(1) : addr_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cx_q   <= '0;
      cy_q   <= '0;
      addr_q <= '0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      addr_q <= addr_d;
    end
  assign cx   = cx_q;
  assign cy   = cy_q;
  assign addr = addr_q;
  assign last = addr_q == ADDR_W'(CELL_W * CELL_H - 1);
endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter: draws one character bitmap from ROM as clipped VGA pixel writes
// clk/resetn: clock and async active-low reset; bus: start/base in, ROM port, VGA port, busy/done
module sprite_plotter import sprite_pkg::*; #(
  parameter int CELL_W = sprite_pkg::CELL_W,
  parameter int CELL_H = sprite_pkg::CELL_H,
  parameter int X_MAX  = sprite_pkg::X_MAX,
  parameter int Y_MAX  = sprite_pkg::Y_MAX
) (
  input logic             clk,
  input logic             resetn,
  sprite_plotter_if.slave bus
);
  localparam int CX_W = $clog2(CELL_W);
  localparam int CY_W = $clog2(CELL_H);
  state_t              state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [X_W-1:0]      base_x_q, base_x_d;
  logic [Y_W-1:0]      base_y_q, base_y_d;
  logic                s1_valid_q, s1_valid_d;
  logic [CX_W-1:0]     s1_cx_q, s1_cx_d;
  logic [CY_W-1:0]     s1_cy_q, s1_cy_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;
  logic                accept, last;
  logic [CX_W-1:0]     cx;
  logic [CY_W-1:0]     cy;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  // walker holds on the last address so rom_addr stays stable after the scan
  cell_walker #(.CELL_W(CELL_W), .CELL_H(CELL_H), .ADDR_W(ADDR_W)) u_walker (
    .clk(clk), .resetn(resetn), .clear(accept), .step(state_q == SCAN && !last),
    .cx(cx), .cy(cy), .addr(bus.rom_addr), .last(last)
  );
  always_comb begin
    accept       = state_q == IDLE && bus.start;
    // DRAIN and FINISH each take one cycle so done lands on the cycle after the last plot
    state_d      = state_q == IDLE ? (bus.start ? SCAN : IDLE)
                 : state_q == SCAN ? (last ? DRAIN : SCAN)
                 : state_q == DRAIN ? FINISH : IDLE;
    busy_d       = accept || (busy_q && state_q != FINISH);
    done_d       = state_q == FINISH;
    base_x_d     = accept ? bus.base_x : base_x_q;
    base_y_d     = accept ? bus.base_y : base_y_q;
    s1_valid_d   = state_q == SCAN;
    s1_cx_d      = cx;
    s1_cy_d      = cy;
    // one extra bit so off-screen sums are clipped rather than wrapped
    sum_x        = (X_W+1)'(base_x_q) + (X_W+1)'(s1_cx_q);
    sum_y        = (Y_W+1)'(base_y_q) + (Y_W+1)'(s1_cy_q);
    vga_plot_d   = s1_valid_q && bus.rom_data != '0
                 && sum_x < (X_W+1)'(X_MAX) && sum_y < (Y_W+1)'(Y_MAX);
    vga_x_d      = vga_plot_d ? sum_x[X_W-1:0] : vga_x_q;
    vga_y_d      = vga_plot_d ? sum_y[Y_W-1:0] : vga_y_q;
    vga_colour_d = vga_plot_d ? bus.rom_data : vga_colour_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_cx_q      <= '0;
      s1_cy_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      s1_valid_q   <= s1_valid_d;
      s1_cx_q      <= s1_cx_d;
      s1_cy_q      <= s1_cy_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: scoreboard bench for sprite_plotter with a synchronous ROM model
module tb_sprite_plotter;
  import sprite_pkg::*;
  typedef struct {int cyc; int x; int y; int c;} exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [COLOUR_W-1:0] rom_mem [32];
  always #5 clk = ~clk;
  sprite_plotter_if bus();
  sprite_plotter dut (.clk(clk), .resetn(resetn), .bus(bus));
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [COLOUR_W-1:0] pattern(input int mode, input int k);
    return mode == 0 ? 3'b100 : mode == 1 ? ((k % 2) ? 3'b010 : 3'b000)
         : mode == 2 ? 3'b101 : COLOUR_W'((k % 7) + 1);
  endfunction
  task automatic run_draw(input int bx, input int by, input int mode,
                          input int restart_cyc, input int reset_cyc);
    int exp_n = 0;
    int got_n = 0;
    exp_t e;
    sb.delete();
    for (int k = 0; k < 32; k++) rom_mem[k] = k < CELL_W * CELL_H ? pattern(mode, k) : '0;
    for (int k = 0; k < CELL_W * CELL_H; k++) begin
      e.cyc = k + 3;
      e.x = bx + k % CELL_W;
      e.y = by + k / CELL_W;
      e.c = int'(rom_mem[k]);
      if (e.c != 0 && e.x < X_MAX && e.y < Y_MAX) begin
        sb.push_back(e);
        exp_n++;
      end
    end
    @(negedge clk);
    bus.base_x = X_W'(bx);
    bus.base_y = Y_W'(by);
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1 || (restart_cyc != 0 && n == restart_cyc + 1)) bus.start = 1'b0;
      if (n == restart_cyc) begin
        bus.start = 1'b1;
        bus.base_x = X_W'(bx + 37);
        bus.base_y = Y_W'(by + 3);
      end
      if (n == reset_cyc) begin
        resetn = 1'b0;
        #1;
        check("midreset_outs", {bus.vga_plot, bus.busy, bus.done}, 0);
        repeat (3) begin
          @(negedge clk);
          check("midreset_hold", {bus.vga_plot, bus.busy, bus.done, bus.rom_addr}, 0);
        end
        resetn = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("post_reset_idle", {bus.vga_plot, bus.busy, bus.done}, 0);
        end
        sb.delete();
        return;
      end
      if (bus.vga_plot) begin
        got_n++;
        if (sb.size() == 0) check("extra_plot", 1, 0);
        else begin
          e = sb.pop_front();
          check("plot_cycle", n, e.cyc);
          check("plot_x", bus.vga_x, e.x);
          check("plot_y", bus.vga_y, e.y);
          check("plot_colour", bus.vga_colour, e.c);
        end
      end
      check("busy", bus.busy, n < 28);
      check("done", bus.done, n == 28);
    end
    check("plot_count", got_n, exp_n);
    check("scoreboard_empty", sb.size(), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.base_x = '0;
    bus.base_y = '0;
    repeat (3) @(negedge clk);
    check("in_reset", {bus.rom_addr, bus.vga_x, bus.vga_y, bus.vga_colour,
                       bus.vga_plot, bus.busy, bus.done}, 0);
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_outs", {bus.rom_addr, bus.vga_x, bus.vga_y, bus.vga_colour,
                          bus.vga_plot, bus.busy, bus.done}, 0);
    end
    run_draw(10, 20, 0, 0, 0);
    run_draw(10, 20, 1, 0, 0);
    run_draw(158, 118, 2, 0, 0);
    run_draw(30, 40, 3, 10, 0);
    run_draw(50, 60, 0, 0, 12);
    run_draw(0, 0, 3, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_plotter.md
# sprite_plotter

Downstream consumer of the character cell scanner. It walks a 5×5 character bitmap stored in a synchronous ROM and turns each non-transparent cell into a pixel write at an absolute screen position. It writes through the VGA adapter's x/y/colour/plot port. A single `start` pulse draws one character at a latched base coordinate. `busy` and `done` give the handshake to the game-level controller.

## Interface
Parameters:
- `CELL_W`, 5, columns per character
- `CELL_H`, 5, rows per character
- `ADDR_W`, 5, ROM address width (≥ clog2(CELL_W·CELL_H))
- `X_W`, 8, screen x width
- `Y_W`, 7, screen y width
- `COLOUR_W`, 3, colour width; value 0 = transparent
- `X_MAX`, 160, screen width; pixels with x ≥ X_MAX are clipped
- `Y_MAX`, 120, screen height; pixels with y ≥ Y_MAX are clipped

Ports:
- `clk` in 1: single clock, all state on its rising edge
- `resetn` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle draw request; sampled only in IDLE
- `base_x` in X_W: character top-left x; latched on accepted `start`
- `base_y` in Y_W: character top-left y; latched on accepted `start`
- `rom_addr` out ADDR_W: bitmap address, row-major (cy·CELL_W + cx)
- `rom_data` in COLOUR_W: ROM output, valid one cycle after `rom_addr`
- `vga_x` out X_W: pixel x
- `vga_y` out Y_W: pixel y
- `vga_colour` out COLOUR_W: pixel colour
- `vga_plot` out 1: write strobe, one cycle per pixel
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse when the draw completes

## Operation
- FSM states and transitions:
  - IDLE → SCAN on `start`.
  - SCAN → DRAIN after address CELL_W·CELL_H−1 is issued.
  - DRAIN → FINISH once the pipeline is empty (2 cycles).
  - FINISH → IDLE unconditionally.
- On `start` in IDLE: latch `base_x` and `base_y`; clear cx, cy and the linear address counter.
- SCAN, address generation: one address per cycle, 0…24 ascending.
  - cx increments each cycle; when cx = CELL_W−1, cx wraps to 0 and cy increments.
  - The address comes from the linear counter. No multiplier.
- Stage 1: cx and cy are delayed one cycle alongside the ROM latency, with a valid bit.
- Stage 2 registers the outputs:
  - `vga_x` = base_x + cx, computed X_W+1 wide.
  - `vga_y` = base_y + cy, computed Y_W+1 wide.
  - `vga_colour` = rom_data.
  - `vga_plot` = valid ∧ rom_data ≠ 0 ∧ sum_x < X_MAX ∧ sum_y < Y_MAX. There is no wrap-around. Overflowing pixels are suppressed, not modulo-wrapped.
- `vga_x`, `vga_y` and `vga_colour` hold their last values when `vga_plot` is low.
- `start` while not IDLE is ignored. No queueing.
- `base_x` and `base_y` changing mid-draw have no effect.
- `resetn` low at any time, including mid-draw, clears everything immediately:
  - State → IDLE.
  - Counters, pipeline valids, `rom_addr`, `vga_x`, `vga_y`, `vga_colour`, `vga_plot`, `busy`, `done` → 0.
  - No partial draw resumes.

## Timing
- Cycle numbering: `start` sampled high at edge E0.
- `busy` = 1 from the cycle after E0.
- `rom_addr` = k in cycle k+1, for k = 0…24.
- The pixel for address k appears on `vga_*` in cycle k+3 (fixed 2-cycle latency from address to plot).
- Last possible plot is in cycle 27. `done` = 1 in cycle 28, and `busy` drops in that same cycle.
- The next `start` is accepted in cycle 28 or later; issue-to-issue minimum is 28 cycles.
- The VGA adapter accepts one write per cycle. There is no back-pressure input.

## Structure
- `sprite_pkg` holds:
  - CELL_W, CELL_H, X_MAX, Y_MAX defaults.
  - The state enum `{IDLE, SCAN, DRAIN, FINISH}`.
  - Coordinate and colour width constants shared with the scanner and the VGA wrapper.
- One sub-module, `cell_walker`: the cx/cy/linear-address counter with `clear`, `step` and `last` outputs, reusable by the upstream scanner.
- FSM and the two pipeline stages stay in `sprite_plotter`.

## Test plan
- Reset then idle:
  - Stimulus: `resetn` low 3 cycles, then high, no `start`.
  - Required response: every output 0 for 10 cycles.
- Full draw:
  - Stimulus: ROM all 3'b100, base (10,20), `start` pulse.
  - Required response: exactly 25 plots in consecutive cycles 3…27, x 10→14 fastest, y 20→24; `done` in cycle 28 only.
- Transparency:
  - Stimulus: ROM checkerboard (even addresses 0, odd 3'b010).
  - Required response: 12 plots, only at odd addresses, e.g. (11,20) and (10,21); cycle positions unchanged; `done` still in cycle 28.
- Clipping:
  - Stimulus: base (158,118), ROM all non-zero.
  - Required response: only 4 plots, at (158,118), (159,118), (158,119), (159,119); x=160 and y=120 never strobed; no wrap to 0.
- Start while busy, and mid-draw reset:
  - Stimulus: second `start` at cycle 10 with a different base.
  - Required response: ignored, first draw unchanged.
  - Stimulus: separate run with `resetn` low at cycle 12.
  - Required response: `vga_plot`, `busy`, `done` = 0 in the same cycle; no `done`; a fresh `start` afterwards draws all 25 pixels normally.
